coco_mem_access_ctrl: RTL
=========================

Name:
coco_mem_access_ctrl

Overview:
- Data-memory access sequencer between the MIPS MEM stage and the data-memory bus.
- Accepts one load/store request from the pipeline and checks address alignment.
- Drives a req/ack bus transaction with byte enables and a lane-shifted store data word.
- Captures the read word and returns it byte/half-extended using the load extension encoding. Stalls the pipeline via Busy while a transaction is outstanding.

Parameters:
- TIMEOUT, 16: maximum cycles in WAIT without MemAck before aborting; legal range 2..255.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- Req  in  1  pipeline access request, sampled in IDLE only
- We  in  1  1 = store, 0 = load
- Funct  in  3  000 word, 001 unsigned byte, 010 unsigned half, 011 signed byte, 100 signed half; stores ignore signedness
- Addr  in  32  byte address
- Wdata  in  32  store data, right-justified
- Busy  out  1  high while state != IDLE; pipeline stalls
- Done  out  1  one-cycle pulse: access completed
- Rdata  out  32  extended load result; held until next load Done
- AdErr  out  1  one-cycle pulse: misaligned address or illegal Funct
- TmoErr  out  1  one-cycle pulse: bus timeout
- MemReq  out  1  bus request, level
- MemWe  out  1  bus write strobe, valid with MemReq
- MemAddr  out  32  {Addr[31:2],2'b00}
- MemBe  out  4  byte enables, bit i = byte lane i (Din[8i+7:8i])
- MemWdata  out  32  store data shifted to lane
- MemAck  in  1  bus completion, one cycle; MemRdata valid same cycle
- MemRdata  in  32  bus read word

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - Busy, Done, AdErr, TmoErr, MemReq, MemWe all 0.
  - MemAddr, MemBe, MemWdata, Rdata all 0.
  - Timeout counter 0.
  - Reset mid-transaction aborts it immediately. No Done or error pulse is produced.
- States: IDLE, WAIT, RESP.
- IDLE, Req=0: stay.
- IDLE, Req=1, request illegal: AdErr=1 next cycle, stay IDLE, no bus activity. Illegal means any of:
  - Funct in 101..111;
  - half access with Addr[0]=1;
  - word access with Addr[1:0]!=0.
- IDLE, Req=1, request legal, next edge:
  - Latch We, Funct, Addr[1:0].
  - Drive MemReq=1, MemWe=We, MemAddr, MemBe, MemWdata.
  - Go to WAIT and clear the counter.
- MemBe:
  - byte: 1<<Addr[1:0];
  - half: 0011 (A=00) or 1100 (A=10);
  - word: 1111.
  - Loads drive the same MemBe.
- MemWdata:
  - byte: {4{Wdata[7:0]}};
  - half: {2{Wdata[15:0]}};
  - word: Wdata.
- WAIT:
  - All Mem* outputs are held stable.
  - MemAck=0: counter increments. When the counter reaches TIMEOUT-1 with no ack: TmoErr=1 next cycle, MemReq=0, go to IDLE.
  - MemAck=1: register MemRdata, MemReq=0, go to RESP. MemAck takes priority over timeout in the same cycle.
- Load extension of the captured word, indexed by latched Addr[1:0]:
  - 001 zero-extends the selected byte.
  - 010 zero-extends the selected half.
  - 011 sign-extends the selected byte (bit 7 of that byte).
  - 100 sign-extends the selected half.
  - 000 passes the word unchanged.
- RESP:
  - Done=1 for exactly one cycle. Rdata updated on loads only; stores leave Rdata unchanged.
  - Go to IDLE.
  - Busy deasserts the cycle after RESP.
- Latency and Busy:
  - Req at cycle 0 gives MemReq at cycle 1.
  - MemAck at cycle k≥1 gives Done at cycle k+1.
  - Busy=1 from cycle 1 through RESP.
- Req while Busy=1 is ignored. The pipeline must hold Req until it sees Done.
- MemAck in IDLE or RESP is ignored.
- Done, AdErr and TmoErr are mutually exclusive.

Test Plan:
- Signed byte load:
  - Stimulus: Req, We=0, Funct=011, Addr=0x103; MemRdata=0x80AA5511, MemAck at cycle 2.
  - Response: MemAddr=0x100, MemBe=1000; Done at cycle 3; Rdata=0xFFFFFF80.
- Unsigned half load:
  - Stimulus: Funct=010, Addr=0x2, MemRdata=0x9ABC1234.
  - Response: MemBe=1100; Rdata=0x00009ABC.
- Byte store:
  - Stimulus: We=1, Funct=001, Addr=0x41, Wdata=0x000000EE.
  - Response: MemWe=1, MemBe=0010, MemWdata=0xEEEEEEEE; Done pulse; Rdata unchanged.
- Misaligned access:
  - Stimulus: Funct=000 with Addr=0x6, then Funct=100 with Addr=0x1.
  - Response: AdErr pulse each time; MemReq never asserted; Busy stays 0.
- Timeout:
  - Stimulus: TIMEOUT=4, no MemAck.
  - Response: MemReq high for 4 cycles; TmoErr pulse; IDLE. A late MemAck afterwards produces no Done.
- Reset mid-WAIT:
  - Stimulus: rst_n=0 for one cycle while MemReq=1.
  - Response: next cycle all outputs 0, state IDLE. A fresh Req is then accepted normally.

Source files
------------

// File: rtl/coco_mem_access_ctrl.sv
// Data-memory access sequencer: checks alignment, runs one req/ack bus transaction
// per pipeline request, and returns byte/half-extended load data.
module coco_mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Req,
    input  logic        We,
    input  logic [2:0]  Funct,
    input  logic [31:0] Addr,
    input  logic [31:0] Wdata,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Rdata,
    output logic        AdErr,
    output logic        TmoErr,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [3:0]  MemBe,
    output logic [31:0] MemWdata,
    input  logic        MemAck,
    input  logic [31:0] MemRdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [2:0]  funct_q, funct_d;
    logic [1:0]  alo_q, alo_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ad_err_q, ad_err_d;
    logic        tmo_err_q, tmo_err_d;

    logic        req_legal;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;

    // Select the addressed byte/half of the bus word and extend it to 32 bits.
    function automatic logic [31:0] load_ext(input logic [2:0] f, input logic [1:0] lo,
                                             input logic [31:0] w);
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        case (lo)
            2'd0:    sb = w[7:0];
            2'd1:    sb = w[15:8];
            2'd2:    sb = w[23:16];
            default: sb = w[31:24];
        endcase
        sh = lo[1] ? w[31:16] : w[15:0];
        case (f)
            3'b001:  load_ext = {24'd0, sb};
            3'b010:  load_ext = {16'd0, sh};
            3'b011:  load_ext = 32'(sb);
            3'b100:  load_ext = 32'(sh);
            default: load_ext = w;
        endcase
    endfunction

    always_comb begin
        req_legal  = 1'b0;
        be_calc    = 4'b0000;
        wdata_calc = Wdata;
        case (Funct)
            3'b000: begin
                req_legal  = (Addr[1:0] == 2'b00);
                be_calc    = 4'b1111;
                wdata_calc = Wdata;
            end
            3'b001, 3'b011: begin
                req_legal  = 1'b1;
                be_calc    = 4'b0001 << Addr[1:0];
                wdata_calc = {4{Wdata[7:0]}};
            end
            3'b010, 3'b100: begin
                req_legal  = ~Addr[0];
                be_calc    = Addr[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{Wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            we_q        <= 1'b0;
            funct_q     <= 3'd0;
            alo_q       <= 2'd0;
            mem_addr_q  <= 32'd0;
            mem_be_q    <= 4'd0;
            mem_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            ad_err_q    <= 1'b0;
            tmo_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            funct_q     <= funct_d;
            alo_q       <= alo_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            ad_err_q    <= ad_err_d;
            tmo_err_q   <= tmo_err_d;
        end
    end

    // Ack wins over timeout when both land on the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (Req && req_legal) state_d = S_WAIT;
            S_WAIT: begin
                if (MemAck)                  state_d = S_RESP;
                else if (cnt_q == TMO_LAST)  state_d = S_IDLE;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        we_d        = we_q;
        funct_d     = funct_q;
        alo_d       = alo_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        ad_err_d    = 1'b0;
        tmo_err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Req) begin
                    if (req_legal) begin
                        we_d        = We;
                        funct_d     = Funct;
                        alo_d       = Addr[1:0];
                        mem_addr_d  = {Addr[31:2], 2'b00};
                        mem_be_d    = be_calc;
                        mem_wdata_d = wdata_calc;
                        cnt_d       = 8'd0;
                    end else begin
                        ad_err_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (MemAck) begin
                    if (!we_q) rdata_d = load_ext(funct_q, alo_q, MemRdata);
                end else if (cnt_q == TMO_LAST) begin
                    tmo_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        Busy     = (state_q != S_IDLE);
        Done     = (state_q == S_RESP);
        MemReq   = (state_q == S_WAIT);
        MemWe    = (state_q == S_WAIT) && we_q;
        MemAddr  = mem_addr_q;
        MemBe    = mem_be_q;
        MemWdata = mem_wdata_q;
        Rdata    = rdata_q;
        AdErr    = ad_err_q;
        TmoErr   = tmo_err_q;
    end

endmodule
